// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding memory read port between an
// instruction fetch requester and a data requester. Data has priority; an
// aging counter forces the instruction side through after STARVE_LIMIT
// back-to-back data wins. Completions are routed back to the issuing side
// together with the address, and a watchdog aborts a read that never returns.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,   // 1..15
  parameter int unsigned TIMEOUT      = 255  // 1..255
) (
  input  logic        clk,
  input  logic        rst_n,

  // Instruction requester
  input  logic        ireq,
  input  logic [15:0] iaddr,
  output logic        igrant,

  // Data requester
  input  logic        dreq,
  input  logic [15:0] daddr,
  output logic        dgrant,

  // Memory read port
  output logic        mem_re,
  output logic [15:0] mem_raddr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,

  // Instruction response
  output logic        iready,
  output logic [15:0] iaddr_out,
  output logic [15:0] idata,

  // Data response
  output logic        dready,
  output logic [15:0] daddr_out,
  output logic [15:0] ddata,

  // Sticky timeout flag
  output logic        err
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
  // Last wait count value before the watchdog fires.
  localparam logic [7:0] LastCnt   = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  state_e     state_q;
  logic [3:0] starve_q;
  logic [7:0] wait_cnt_q;
  logic       owner_q;  // 1: outstanding read belongs to the instruction side

  logic       any_req;
  logic       starved;
  logic       pick_instr;
  logic [3:0] starve_inc;
  logic       timeout_hit;

  // Winner selection and saturating aging increment for the current IDLE edge.
  always_comb begin
    any_req     = ireq | dreq;
    starved     = (starve_q >= StarveLim);
    pick_instr  = ireq & (~dreq | starved);
    starve_inc  = (starve_q == 4'hf) ? 4'hf : starve_q + 4'd1;
    timeout_hit = (wait_cnt_q == LastCnt);
  end

  // Arbiter FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      starve_q   <= 4'd0;
      wait_cnt_q <= 8'd0;
      owner_q    <= 1'b0;
      igrant     <= 1'b0;
      dgrant     <= 1'b0;
      mem_re     <= 1'b0;
      mem_raddr  <= 16'h0000;
      iready     <= 1'b0;
      iaddr_out  <= 16'h0000;
      idata      <= 16'h0000;
      dready     <= 1'b0;
      daddr_out  <= 16'h0000;
      ddata      <= 16'h0000;
      err        <= 1'b0;
    end else begin
      // Grant, strobe and response outputs are single-cycle pulses.
      igrant <= 1'b0;
      dgrant <= 1'b0;
      mem_re <= 1'b0;
      iready <= 1'b0;
      dready <= 1'b0;

      case (state_q)
        StIdle: begin
          // Aging only accumulates while the instruction side is waiting.
          if (!ireq) begin
            starve_q <= 4'd0;
          end
          if (any_req) begin
            mem_re     <= 1'b1;
            wait_cnt_q <= 8'd0;
            owner_q    <= pick_instr;
            state_q    <= StWait;
            if (pick_instr) begin
              igrant    <= 1'b1;
              mem_raddr <= iaddr;
              starve_q  <= 4'd0;
            end else begin
              dgrant    <= 1'b1;
              mem_raddr <= daddr;
              if (ireq) begin
                starve_q <= starve_inc;
              end
            end
          end
        end

        StWait: begin
          // A completion on the same edge as the watchdog still counts.
          if (mem_ready) begin
            state_q <= StIdle;
            if (owner_q) begin
              iready    <= 1'b1;
              iaddr_out <= mem_raddr;
              idata     <= mem_rdata;
            end else begin
              dready    <= 1'b1;
              daddr_out <= mem_raddr;
              ddata     <= mem_rdata;
            end
          end else if (timeout_hit) begin
            err     <= 1'b1;
            state_q <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single reads, priority/aging order,
// response routing, watchdog abort and reset during an outstanding read.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq, dreq, mem_ready;
  logic [15:0] iaddr, daddr, mem_rdata;
  logic        igrant, dgrant, mem_re, iready, dready, err;
  logic [15:0] mem_raddr, iaddr_out, idata, daddr_out, ddata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT     (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ireq     (ireq),
    .iaddr    (iaddr),
    .igrant   (igrant),
    .dreq     (dreq),
    .daddr    (daddr),
    .dgrant   (dgrant),
    .mem_re   (mem_re),
    .mem_raddr(mem_raddr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .iready   (iready),
    .iaddr_out(iaddr_out),
    .idata    (idata),
    .dready   (dready),
    .daddr_out(daddr_out),
    .ddata    (ddata),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one active edge; inputs are driven and outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ireq      = 1'b0;
    dreq      = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Present one completion for a single edge; returns in the response cycle.
  task automatic mem_respond(input logic [15:0] data);
    mem_ready = 1'b1;
    mem_rdata = data;
    step();
    mem_ready = 1'b0;
  endtask

  logic [9:0] exp_i;  // 1 = instruction expected to win grant k
  logic       is_i;

  initial begin
    rst_n = 1'b0; ireq = 1'b1; dreq = 1'b1; mem_ready = 1'b0;
    iaddr = 16'h0011; daddr = 16'h0022; mem_rdata = 16'h0000;
    @(negedge clk);

    // 1. Reset held with both requests asserted.
    step(); step(); step();
    check("rst_igrant", igrant, 0);
    check("rst_dgrant", dgrant, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_raddr", mem_raddr, 0);
    check("rst_iready", iready, 0);
    check("rst_dready", dready, 0);
    check("rst_idata", {iaddr_out, idata}, 0);
    check("rst_ddata", {daddr_out, ddata}, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    step();
    check("rel_dgrant", dgrant, 1);
    check("rel_igrant", igrant, 0);
    check("rel_raddr", mem_raddr, 16'h0022);

    // 2. Single instruction read, memory answers 3 cycles after mem_re.
    do_reset();
    ireq = 1'b1; iaddr = 16'h0040;
    step();
    check("t2_igrant", igrant, 1);
    check("t2_mem_re", mem_re, 1);
    check("t2_raddr", mem_raddr, 16'h0040);
    ireq = 1'b0;
    step();
    check("t2_grant_pulse", {igrant, mem_re}, 0);
    step();
    step();
    check("t2_no_early_resp", iready, 0);
    mem_respond(16'hBEEF);
    check("t2_iready", iready, 1);
    check("t2_iaddr_out", iaddr_out, 16'h0040);
    check("t2_idata", idata, 16'hBEEF);
    check("t2_dready", dready, 0);
    step();
    check("t2_iready_pulse", iready, 0);
    check("t2_idata_hold", idata, 16'hBEEF);

    // 3. Both held continuously: D,D,D,D,I,D,D,D,D,I (grant 0 first).
    do_reset();
    ireq = 1'b1; dreq = 1'b1; iaddr = 16'h0100; daddr = 16'h0200;
    exp_i = 10'b10000_10000;
    for (int k = 0; k < 10; k++) begin
      step();
      is_i = exp_i[k];
      check($sformatf("t3_igrant_%0d", k), igrant, is_i);
      check($sformatf("t3_dgrant_%0d", k), dgrant, !is_i);
      check($sformatf("t3_raddr_%0d", k), mem_raddr, is_i ? 16'h0100 : 16'h0200);
      mem_respond(16'(k));
      check($sformatf("t3_route_%0d", k), {iready, dready}, is_i ? 2'b10 : 2'b01);
    end
    ireq = 1'b0; dreq = 1'b0;

    // 4. Data completion while an instruction request waits.
    do_reset();
    ireq = 1'b1; dreq = 1'b1; iaddr = 16'h2000; daddr = 16'h1000;
    step();
    check("t4_dgrant", dgrant, 1);
    dreq = 1'b0;
    step();
    check("t4_no_grant_in_wait", {igrant, dgrant}, 0);
    mem_respond(16'h1234);
    check("t4_dready", dready, 1);
    check("t4_ddata", ddata, 16'h1234);
    check("t4_daddr_out", daddr_out, 16'h1000);
    check("t4_iready", iready, 0);
    check("t4_idata_unch", idata, 16'h0000);
    step();
    check("t4_igrant", igrant, 1);
    check("t4_raddr_i", mem_raddr, 16'h2000);
    ireq = 1'b0;
    mem_respond(16'h5678);
    check("t4_iready", iready, 1);
    check("t4_idata", idata, 16'h5678);
    check("t4_ddata_hold", ddata, 16'h1234);

    // 5a. Completion on the watchdog edge wins.
    do_reset();
    dreq = 1'b1; daddr = 16'h3000;
    step();
    dreq = 1'b0;
    for (int k = 0; k < 7; k++) step();
    mem_respond(16'hCAFE);
    check("t5a_dready", dready, 1);
    check("t5a_ddata", ddata, 16'hCAFE);
    check("t5a_err", err, 0);

    // 5b. Memory never answers: abort after 8 WAIT cycles.
    do_reset();
    dreq = 1'b1; daddr = 16'h3000;
    step();
    check("t5_dgrant", dgrant, 1);
    dreq = 1'b0;
    for (int k = 0; k < 7; k++) step();
    check("t5_err_before", err, 0);
    step();
    check("t5_err", err, 1);
    check("t5_no_resp", {iready, dready}, 0);
    mem_respond(16'hDEAD);
    check("t5_stray_ignored", {iready, dready}, 0);
    check("t5_ddata_unch", ddata, 16'h0000);
    ireq = 1'b1; iaddr = 16'h4000;
    step();
    check("t5_next_igrant", igrant, 1);
    check("t5_err_sticky", err, 1);
    ireq = 1'b0;
    mem_respond(16'hAAAA);
    check("t5_iready", iready, 1);
    check("t5_idata", idata, 16'hAAAA);
    check("t5_err_sticky2", err, 1);

    // 6. Reset during WAIT; the late completion must be dropped.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_err_cleared", err, 0);
    dreq = 1'b1; daddr = 16'h5000;
    step();
    check("t6_dgrant", dgrant, 1);
    dreq = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_raddr_rst", mem_raddr, 0);
    step();
    mem_respond(16'h7777);
    check("t6_no_resp", {iready, dready}, 0);
    check("t6_ddata", ddata, 16'h0000);
    check("t6_err", err, 0);
    ireq = 1'b1; iaddr = 16'h6000;
    step();
    check("t6_idle_igrant", igrant, 1);
    ireq = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
